// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W     = 8;
  localparam int DMEM_DATA_W     = 32;
  localparam int DMEM_STARVE_MAX = 4;

  // Which requester owns the read that is in flight to the memory.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_CPU  = 2'd1,
    REQ_DBG  = 2'd2
  } req_owner_e;

  // Arbitration priority state.
  typedef enum logic {
    CPU_PRI    = 1'b0,
    DBG_FORCED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating 32-bit grant/conflict counters for the data-memory arbiter.
// Only instantiated when DMEM_ARB_STATS_EN is defined.
module dmem_arb_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_gnt,
  input  logic        dbg_gnt,
  input  logic        conflict,
  output logic [31:0] stat_cpu_grants,
  output logic [31:0] stat_dbg_grants,
  output logic [31:0] stat_conflicts
);

  logic [31:0] cpu_cnt_q, cpu_cnt_d;
  logic [31:0] dbg_cnt_q, dbg_cnt_d;
  logic [31:0] cfl_cnt_q, cfl_cnt_d;

  // Each counter sticks at all-ones instead of wrapping.
  always_comb begin
    cpu_cnt_d = cpu_cnt_q;
    dbg_cnt_d = dbg_cnt_q;
    cfl_cnt_d = cfl_cnt_q;
    if (cpu_gnt  && (cpu_cnt_q != '1)) cpu_cnt_d = cpu_cnt_q + 32'd1;
    if (dbg_gnt  && (dbg_cnt_q != '1)) dbg_cnt_d = dbg_cnt_q + 32'd1;
    if (conflict && (cfl_cnt_q != '1)) cfl_cnt_d = cfl_cnt_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_cnt_q <= '0;
      dbg_cnt_q <= '0;
      cfl_cnt_q <= '0;
    end else begin
      cpu_cnt_q <= cpu_cnt_d;
      dbg_cnt_q <= dbg_cnt_d;
      cfl_cnt_q <= cfl_cnt_d;
    end
  end

  assign stat_cpu_grants = cpu_cnt_q;
  assign stat_dbg_grants = dbg_cnt_q;
  assign stat_conflicts  = cfl_cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter for the single-port data memory shared by the CPU MEM stage and
// the debug/loader port. Grants at most one access per cycle, forces a debug
// win after STARVE_MAX consecutive denied debug cycles, and routes the
// one-cycle-late read data back to whichever requester issued the read.
// Optional statistics counters: define DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = DMEM_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_we,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  output logic              dbg_rsp_valid,
  output logic [DATA_W-1:0] dbg_rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       stat_cpu_grants,
  output logic [31:0]       stat_dbg_grants,
  output logic [31:0]       stat_conflicts
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  req_owner_e        owner_q, owner_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              cpu_gnt, dbg_gnt;

  // Arbitration state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CPU_PRI;
    else     state_q <= state_d;
  end

  // Next state: force debug once the counter is about to hit the limit, so
  // debug wins on the cycle right after its STARVE_MAX-th denial.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CPU_PRI:    if (starve_d == STARVE_LIM) state_d = DBG_FORCED;
      DBG_FORCED: if (dbg_gnt || !dbg_req_valid) state_d = CPU_PRI;
      default:    state_d = CPU_PRI;
    endcase
  end

  // Grant outputs; nothing is granted while reset is asserted.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      case (state_q)
        CPU_PRI: begin
          if (cpu_req_valid)      cpu_gnt = 1'b1;
          else if (dbg_req_valid) dbg_gnt = 1'b1;
        end
        DBG_FORCED: begin
          if (dbg_req_valid)      dbg_gnt = 1'b1;
          else if (cpu_req_valid) cpu_gnt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cpu_req_ready = cpu_gnt;
  assign dbg_req_ready = dbg_gnt;

  // Starvation counter: counts consecutive denied debug cycles, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!dbg_req_valid || dbg_gnt)  starve_d = '0;
    else if (starve_q != STARVE_LIM) starve_d = starve_q + CNT_W'(1);
  end

  // Memory port mux from the granted requester; zero when idle.
  always_comb begin
    mem_en    = cpu_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_req_we;
      mem_addr  = cpu_req_addr;
      mem_wdata = cpu_req_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_req_we;
      mem_addr  = dbg_req_addr;
      mem_wdata = dbg_req_wdata;
    end
  end

  // Read owner tracking and per-port read-data hold.
  always_comb begin
    owner_d = REQ_NONE;
    if (cpu_gnt && !cpu_req_we)      owner_d = REQ_CPU;
    else if (dbg_gnt && !dbg_req_we) owner_d = REQ_DBG;
    cpu_rdata_d = (owner_q == REQ_CPU) ? mem_rdata : cpu_rdata_q;
    dbg_rdata_d = (owner_q == REQ_DBG) ? mem_rdata : dbg_rdata_q;
  end

  // Counter, owner and held read data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q    <= '0;
      owner_q     <= REQ_NONE;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // The response cycle passes memory data straight through; otherwise the
  // last returned word is held.
  assign cpu_rsp_valid = (owner_q == REQ_CPU);
  assign dbg_rsp_valid = (owner_q == REQ_DBG);
  assign cpu_rsp_rdata = cpu_rdata_d;
  assign dbg_rsp_rdata = dbg_rdata_d;

`ifdef DMEM_ARB_STATS_EN
  logic conflict;
  assign conflict = cpu_req_valid & dbg_req_valid;

  dmem_arb_stats u_stats (
    .clk             (clk),
    .rst             (rst),
    .cpu_gnt         (cpu_gnt),
    .dbg_gnt         (dbg_gnt),
    .conflict        (conflict),
    .stat_cpu_grants (stat_cpu_grants),
    .stat_dbg_grants (stat_dbg_grants),
    .stat_conflicts  (stat_conflicts)
  );
`else
  assign stat_cpu_grants = '0;
  assign stat_dbg_grants = '0;
  assign stat_conflicts  = '0;
`endif

endmodule
